// File: rtl/subbytes_sched.sv
// subbytes_sched: shares one external 4-lane S-box slice between the cipher
// state (four 32-bit beats) and the key-expansion SubWord (one beat).
// Arbitration is per cycle, so a key word can slip between state beats.
// Optional build macro SUBBYTES_SCHED_RR_EN: round-robin between key and
// state on contested cycles instead of fixed key priority.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no state job; first state beat (lane 0) may be granted
//   ST_BEAT | state job running, beat counter k selects the next lane
module subbytes_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req,
   input  logic [127:0] st_in,
   output logic         st_done,
   output logic [127:0] st_out,
   input  logic         kw_req,
   input  logic [31:0]  kw_in,
   output logic         kw_done,
   output logic [31:0]  kw_out,
   output logic         busy,
   output logic [31:0]  sb_in,
   input  logic [31:0]  sb_out
);

   typedef enum logic {
      IDLE    = 1'b0,
      ST_BEAT = 1'b1
   } state_t;

   state_t      state;
   logic [1:0]  k;
   logic        key_cand;
   logic        st_cand;
   logic        key_gnt;
   logic        st_gnt;
   logic [31:0] st_lane;

`ifdef SUBBYTES_SCHED_RR_EN
   // 1: key wins the next contested cycle, 0: state wins it
   logic        rr_key;
`endif

   // Candidates and grant; done pulses act as acknowledges, masking the
   // request they answer, which also keeps the key from holding the slice
   // on two consecutive cycles.
   always_comb begin
      key_cand = kw_req & ~kw_done & ~rst;
      st_cand  = (((state == IDLE) & st_req & ~st_done) | (state == ST_BEAT)) & ~rst;
`ifdef SUBBYTES_SCHED_RR_EN
      key_gnt  = key_cand & (~st_cand | rr_key);
`else
      key_gnt  = key_cand;
`endif
      st_gnt   = st_cand & ~key_gnt;
   end

   // State lane for the current beat, most significant word first
   always_comb begin
      st_lane = st_in[127:96];
      case (k)
         2'd0: st_lane = st_in[127:96];
         2'd1: st_lane = st_in[95:64];
         2'd2: st_lane = st_in[63:32];
         2'd3: st_lane = st_in[31:0];
         default: st_lane = st_in[127:96];
      endcase
   end

   // Slice input follows the grant; idle slice sees zero
   always_comb begin
      sb_in = 32'h0;
      if (key_gnt)
         sb_in = kw_in;
      else if (st_gnt)
         sb_in = st_lane;
   end

   // FSM, beat counter, result capture and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         k       <= 2'd0;
         st_done <= 1'b0;
         st_out  <= 128'h0;
         kw_done <= 1'b0;
         kw_out  <= 32'h0;
         busy    <= 1'b0;
`ifdef SUBBYTES_SCHED_RR_EN
         rr_key  <= 1'b0;
`endif
      end else begin
         kw_done <= key_gnt;
         if (key_gnt)
            kw_out <= sb_out;

         st_done <= 1'b0;
         if (st_gnt) begin
            case (k)
               2'd0: st_out[127:96] <= sb_out;
               2'd1: st_out[95:64]  <= sb_out;
               2'd2: st_out[63:32]  <= sb_out;
               2'd3: st_out[31:0]   <= sb_out;
               default: st_out[127:96] <= sb_out;
            endcase
            k <= k + 2'd1;
            if (k == 2'd3) begin
               state   <= IDLE;
               st_done <= 1'b1;
            end else begin
               state   <= ST_BEAT;
            end
            // stays high through the done cycle
            busy <= 1'b1;
         end else begin
            busy <= (state == ST_BEAT);
         end

`ifdef SUBBYTES_SCHED_RR_EN
         // only contested cycles move the pointer, away from the winner
         if (key_cand & st_cand)
            rr_key <= st_gnt;
`endif
      end
   end

endmodule
